// File: rtl/picorv_mem_arb.sv
// picorv_mem_arb: two-master round-robin arbiter onto a single PicoRV32-style memory port.
// Define PICORV_MEM_ARB_TIMEOUT_EN to enable forced completion after TIMEOUT_CYCLES stalled slave cycles.
module picorv_mem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        timeout_err
);

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picorv_mem_arb: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rr_q, rr_d;
  logic   owner_q, owner_d;
  logic   busy0, busy1, force_done, done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Reset masks the busy decode so an abandoned transfer never reaches the ports.
  assign busy0 = (state_q == BUSY0) && !reset;
  assign busy1 = (state_q == BUSY1) && !reset;

`ifdef PICORV_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Every grant leaves IDLE, so holding the counter clear in IDLE clears it on grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = '0;
    else if (!s_ready)    cnt_d = cnt_q + CNT_W'(1);
  end

  assign force_done = (busy0 || busy1) && !s_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign force_done = 1'b0;
`endif

  assign done = s_ready || force_done;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (m0_valid && (!m1_valid || !rr_q)) begin
          state_d = BUSY0;
          owner_d = 1'b0;
        end else if (m1_valid) begin
          state_d = BUSY1;
          owner_d = 1'b1;
        end
      end
      BUSY0: begin
        if (done) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end
      end
      BUSY1: begin
        if (done) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_valid = busy0 || busy1;
  assign s_instr = busy0 ? m0_instr : (busy1 ? m1_instr : 1'b0);
  assign s_addr  = busy0 ? m0_addr  : (busy1 ? m1_addr  : 32'h0);
  assign s_wdata = busy0 ? m0_wdata : (busy1 ? m1_wdata : 32'h0);
  assign s_wstrb = busy0 ? m0_wstrb : (busy1 ? m1_wstrb : 4'h0);

  assign m0_ready = busy0 && done;
  assign m1_ready = busy1 && done;
  assign m0_rdata = (busy0 && force_done) ? TIMEOUT_RDATA : s_rdata;
  assign m1_rdata = (busy1 && force_done) ? TIMEOUT_RDATA : s_rdata;

  assign owner       = owner_q;
  assign timeout_err = force_done;

endmodule

// File: tb/tb_picorv_mem_arb.sv
// Self-checking bench for picorv_mem_arb: directed scenarios then random traffic vs a behavioural model.
// Timeout scenarios run only when PICORV_MEM_ARB_TIMEOUT_EN is defined.
module tb_picorv_mem_arb;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;
`ifdef PICORV_MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mv, mi, mr;
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic [31:0] mrd [2];
  logic        s_valid, s_instr, s_ready, owner, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  picorv_mem_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
    .m0_ready(mr[0]), .m0_rdata(mrd[0]),
    .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
    .m1_ready(mr[1]), .m1_rdata(mrd[1]),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the slave (-1 none), whose turn a tie is, last grantee, stalled cycles.
  int grant = -1;
  int rr    = 0;
  int own   = 0;
  int busy  = 0;
  logic [1:0] done_v = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Check one cycle of DUT outputs against the model, then advance the model across the clock edge.
  task automatic tick();
    int g;
    bit fire;
    logic        ei;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    #1;
    g    = reset ? -1 : grant;
    fire = TO_EN && (g >= 0) && !s_ready && (busy == int'(TO));
    ei = 1'b0; ea = '0; ew = '0; es = '0;
    if (g >= 0) begin
      ei = mi[g]; ea = ma[g]; ew = mw[g]; es = ms[g];
    end
    chk("s_valid", 32'(s_valid), 32'(g >= 0));
    chk("s_instr", 32'(s_instr), 32'(ei));
    chk("s_addr",  s_addr,  ea);
    chk("s_wdata", s_wdata, ew);
    chk("s_wstrb", 32'(s_wstrb), 32'(es));
    for (int n = 0; n < 2; n++) begin
      done_v[n] = (g == n) && (s_ready || fire);
      chk($sformatf("m%0d_ready", n), 32'(mr[n]), 32'(done_v[n]));
      chk($sformatf("m%0d_rdata", n), mrd[n], (fire && g == n) ? DEAD : s_rdata);
    end
    chk("owner", 32'(owner), 32'(own));
    chk("timeout_err", 32'(timeout_err), 32'(fire));
    if (reset) begin
      grant = -1; rr = 0; own = 0; busy = 0;
    end else if (grant < 0) begin
      if (mv != 2'b00) begin
        grant = (mv == 2'b11) ? rr : (mv[1] ? 1 : 0);
        own   = grant;
        busy  = 0;
      end
    end else if (s_ready || fire) begin
      rr    = 1 - grant;
      grant = -1;
    end else begin
      busy++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int n, input logic instr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb);
    mv[n] = 1'b1; mi[n] = instr; ma[n] = addr; mw[n] = wdata; ms[n] = wstrb;
  endtask

  initial begin
    reset = 1'b1; mv = '0; mi = '0; s_ready = 1'b0; s_rdata = '0;
    for (int n = 0; n < 2; n++) begin ma[n] = '0; mw[n] = '0; ms[n] = '0; end
    @(posedge clk); #1;

    // Reset state, with a stray slave ready that must be ignored
    s_ready = 1'b1;
    tick(); tick();
    chk("rst_owner", 32'(owner), 32'h0);
    reset = 1'b0;
    tick();
    s_ready = 1'b0;

    // Simultaneous requests: m0 first, bubble, then m1 beats an immediate m0 re-request
    req(0, 1'b1, 32'h0000_0A00, 32'h0, 4'h0);
    req(1, 1'b0, 32'h0000_0B00, 32'h1111_2222, 4'h3);
    tick();
    chk("035_first_owner", 32'(owner), 32'h0);
    chk("035_first_addr", s_addr, 32'h0000_0A00);
    s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
    tick();
    s_ready = 1'b0;
    req(0, 1'b0, 32'h0000_0A40, 32'h0, 4'h0);
    #1 chk("035_bubble", 32'(s_valid), 32'h0);
    tick();
    chk("035_second_owner", 32'(owner), 32'h1);
    chk("035_second_addr", s_addr, 32'h0000_0B00);
    s_ready = 1'b1;
    tick();
    mv[1] = 1'b0; s_ready = 1'b0;
    tick();
    chk("035_third_owner", 32'(owner), 32'h0);
    chk("035_third_addr", s_addr, 32'h0000_0A40);
    s_ready = 1'b1;
    tick();
    mv[0] = 1'b0; s_ready = 1'b0;
    tick();

    // m0 read of 0x100, slave answers on its third busy cycle
    req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    s_rdata = 32'h1234_5678;
    tick();
    chk("034_latency", 32'(s_valid), 32'h1);
    tick(); tick();
    s_ready = 1'b1;
    #1;
    chk("034_m0_ready", 32'(mr[0]), 32'h1);
    chk("034_m0_rdata", mrd[0], 32'h1234_5678);
    chk("034_m1_ready", 32'(mr[1]), 32'h0);
    chk("034_owner", 32'(owner), 32'h0);
    tick();
    mv[0] = 1'b0; s_ready = 1'b0;
    #1 chk("034_ready_one_cycle", 32'(mr[0]), 32'h0);
    tick();

    // m1 write with m0 idle
    req(1, 1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 4'hF);
    tick();
    chk("036_addr",  s_addr,  32'h0000_0200);
    chk("036_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("036_wstrb", 32'(s_wstrb), 32'hF);
    chk("036_owner", 32'(owner), 32'h1);
    s_ready = 1'b1;
    #1 chk("036_m0_ready", 32'(mr[0]), 32'h0);
    tick();
    mv[1] = 1'b0; s_ready = 1'b0;
    tick();

    // Reset two cycles into a stalled transfer abandons it silently
    req(0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("037_s_valid_in_reset", 32'(s_valid), 32'h0);
    chk("037_m0_ready_in_reset", 32'(mr[0]), 32'h0);
    tick();
    reset = 1'b0; mv[0] = 1'b0;
    #1;
    chk("037_s_valid_after", 32'(s_valid), 32'h0);
    chk("037_owner_after", 32'(owner), 32'h0);
    tick();

`ifdef PICORV_MEM_ARB_TIMEOUT_EN
    // Slave never answers: forced completion on the cycle the stall count reaches TO
    req(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    s_rdata = 32'h5555_AAAA;
    tick();
    for (int i = 0; i < int'(TO); i++) tick();
    #1;
    chk("038_m0_ready", 32'(mr[0]), 32'h1);
    chk("038_m0_rdata", mrd[0], DEAD);
    chk("038_timeout_err", 32'(timeout_err), 32'h1);
    tick();
    mv[0] = 1'b0;
    #1 chk("038_err_one_cycle", 32'(timeout_err), 32'h0);
    tick();

    // Slave ready on the timeout cycle wins
    req(1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < int'(TO); i++) tick();
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    #1;
    chk("039_m1_ready", 32'(mr[1]), 32'h1);
    chk("039_m1_rdata", mrd[1], 32'h0BAD_F00D);
    chk("039_timeout_err", 32'(timeout_err), 32'h0);
    tick();
    mv[1] = 1'b0; s_ready = 1'b0;
    tick();
`endif

    // Random traffic: random requests, slave latency, stray ready in idle, early valid drops
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (done_v[n]) mv[n] = 1'b0;
        if (mv[n] && grant == n && $urandom_range(15) == 0) mv[n] = 1'b0;
        if (!mv[n] && grant != n && $urandom_range(3) == 0)
          req(n, 1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      s_ready = ($urandom_range(2) == 0);
      s_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/picorv_mem_arb.md
PICORV_MEM_ARB -- requirements
Module: picorv_mem_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set slave cycles allowed per transfer before forced completion (range 1..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 mN_valid  input  1  (N=0,1) SHALL be the master N request, held high until mN_ready.
REQ-005 mN_instr  input  1  SHALL flag an instruction fetch from master N.
REQ-006 mN_addr / mN_wdata  input  32 each  SHALL be the master N address and write data.
REQ-007 mN_wstrb  input  4  SHALL be the master N byte write strobes; 0 = read.
REQ-008 mN_ready  output  1  SHALL be the master N completion strobe.
REQ-009 mN_rdata  output  32  SHALL be the read data returned to master N.
REQ-010 s_valid, s_instr, s_addr, s_wdata, s_wstrb  output  1/1/32/32/4  SHALL form the shared slave request.
REQ-011 s_ready  input  1  and  s_rdata  input  32  SHALL be the slave completion and read data.
REQ-012 owner  output  1  SHALL give the index of the currently granted master.
REQ-013 timeout_err  output  1  SHALL be a one-cycle pulse on forced completion.

Function
REQ-014 States SHALL be IDLE, BUSY0, BUSY1; BUSYn means master n owns the slave.
REQ-015 IDLE with one mN_valid high SHALL go to BUSYN next cycle.
REQ-016 IDLE with both valid SHALL grant the master selected by the round-robin pointer rr.
REQ-017 On every grant completion rr SHALL point to the master not just served.
REQ-018 In BUSYn, s_valid SHALL be 1 and s_instr/s_addr/s_wdata/s_wstrb SHALL equal master n's inputs combinationally.
REQ-019 In IDLE, s_valid SHALL be 0 and other slave outputs 0.
REQ-020 mn_ready SHALL equal s_ready AND state==BUSYn; the other master's ready SHALL be 0.
REQ-021 m0_rdata and m1_rdata SHALL both equal s_rdata except during forced completion.
REQ-022 On s_ready in BUSYn the next state SHALL be IDLE; one idle bubble between transfers is mandatory.
REQ-023 Arbitration latency SHALL be exactly one cycle from mN_valid rise (in IDLE) to s_valid.
REQ-024 A master dropping valid while granted SHALL NOT abort; the arbiter SHALL hold the transfer until s_ready.
REQ-025 s_ready seen in IDLE SHALL be ignored.
REQ-026 owner SHALL reflect the last granted master and hold in IDLE.

Reset
REQ-027 Reset SHALL force state IDLE, rr=0 (master 0 first), owner=0, timeout counter 0.
REQ-028 During and after reset: s_valid=0, m0_ready=m1_ready=0, timeout_err=0.
REQ-029 Reset asserted mid-transfer SHALL abandon it with no ready pulse to any master.

Configuration
REQ-030 With PICORV_MEM_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on grant and increment each BUSY cycle without s_ready.
REQ-031 With it defined, when counter reaches TIMEOUT_CYCLES without s_ready: mn_ready=1, mn_rdata=32'hDEADBEEF, timeout_err=1 for that cycle, next state IDLE, rr advances.
REQ-032 s_ready arriving in the same cycle as timeout SHALL win: normal completion, no timeout_err.
REQ-033 Without the macro, no counter SHALL exist, transfers SHALL wait indefinitely, timeout_err SHALL be tied 0.

Verification
REQ-034 m0 read addr 0x100, slave ready after 3 cycles, s_rdata 0x12345678 -> s_valid 1 cycle after request, m0_ready one cycle, m0_rdata 0x12345678, owner 0.
REQ-035 m0 and m1 valid same cycle after reset -> m0 served first, then IDLE bubble, then m1; next simultaneous pair served m1 first.
REQ-036 m1 write addr 0x200, wdata 0xA5A5A5A5, wstrb 0xF while m0 idle -> s_addr/s_wdata/s_wstrb match, m0_ready stays 0.
REQ-037 Reset high two cycles after grant with s_ready low -> IDLE next cycle, no mN_ready, s_valid 0.
REQ-038 Macro defined, TIMEOUT_CYCLES=4, slave never ready -> after 4 BUSY cycles m0_ready=1, m0_rdata 0xDEADBEEF, timeout_err one cycle.
REQ-039 Macro defined, s_ready on exactly the timeout cycle -> normal completion, timeout_err 0.
